// File: rtl/hack_pkg.sv
// hack_pkg: shared widths and loader state encoding for the Hack ROM loader
// No ports; imported by loader_frame_fsm and hack_rom_loader.
package hack_pkg;
   localparam int WORD_W     = 16;
   localparam int ROM_ADDR_W = 15;
   localparam int ROM_DEPTH  = 32768;
   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      DATA_HI,
      DATA_LO,
      CHK,
      DONE,
      ERR
   } loader_state_t;
endpackage

// File: rtl/loader_frame_fsm.sv
// loader_frame_fsm: parses the length/data/checksum byte frame and tracks load status
// clk, reset        : clock and synchronous active-high reset
// start             : restart request, honoured only in DONE or ERR
// in_valid, in_data : byte stream in; in_ready : byte taken when in_valid && in_ready
// wr, wr_word       : pulse on the cycle a word's low byte is taken, with the assembled word
// restart           : start was honoured this cycle
// done, error       : registered status, high only in DONE / ERR respectively
module loader_frame_fsm
   import hack_pkg::*;
#(
   parameter int DEPTH = ROM_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr,
   output logic [WORD_W-1:0] wr_word,
   output logic              restart,
   output logic              done,
   output logic              error
);
   loader_state_t state, state_n;
   logic [7:0]  hi;
   logic [7:0]  csum;
   logic [15:0] rem;
   logic [15:0] n;
   logic        acc;
   always_comb begin
      in_ready = !reset && (state inside {HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK});
      acc      = in_valid && in_ready;
      n        = {hi, in_data};
      restart  = start && (state inside {DONE, ERR});
      wr       = acc && state == DATA_LO;
      wr_word  = {hi, in_data};
      state_n  = state;
      case (state)
         HDR_HI:    state_n = acc ? HDR_LO : state;
         HDR_LO:    state_n = !acc ? state : ({1'b0, n} > 17'(DEPTH)) ? ERR : (n == '0) ? CHK : DATA_HI;
         DATA_HI:   state_n = acc ? DATA_LO : state;
         DATA_LO:   state_n = !acc ? state : (rem == 16'd1) ? CHK : DATA_HI;
         CHK:       state_n = !acc ? state : (in_data == csum) ? DONE : ERR;
         DONE, ERR: state_n = restart ? HDR_HI : state;
         default:   state_n = HDR_HI;
      endcase
   end
   // hi holds the header high byte and then each data word's high byte;
   // rem counts words still to arrive, including the one in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= HDR_HI;
         hi    <= '0;
         csum  <= '0;
         rem   <= '0;
         done  <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= state_n;
         done  <= state_n == DONE;
         error <= state_n == ERR;
         if (restart) begin
            hi   <= '0;
            csum <= '0;
            rem  <= '0;
         end
         if (acc && state != CHK) csum <= csum ^ in_data;
         if (acc && (state == HDR_HI || state == DATA_HI)) hi <= in_data;
         if (acc && state == HDR_LO) rem <= n;
         if (wr) rem <= rem - 16'd1;
      end
   end
endmodule

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: fills the Hack instruction ROM from a checksummed byte stream
// clk, reset        : clock and synchronous active-high reset
// start             : pulse to begin a new load from DONE or ERR
// in_valid, in_data : byte stream in; in_ready : byte taken when in_valid && in_ready
// rom_we, rom_addr, rom_data : registered ROM write port, one strobe per word
// cpu_hold          : hold the CPU in reset until a verified image is loaded
// done, error       : load verified / load failed
// words_loaded      : words written in the current load
module hack_rom_loader
   import hack_pkg::*;
#(
   parameter int ADDR_W = ROM_ADDR_W,
   parameter int DEPTH  = ROM_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [WORD_W-1:0] rom_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_loaded
);
   logic              wr;
   logic              restart;
   logic [WORD_W-1:0] wr_word;
   loader_frame_fsm #(.DEPTH(DEPTH)) u_fsm (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr       (wr),
      .wr_word  (wr_word),
      .restart  (restart),
      .done     (done),
      .error    (error)
   );
   assign cpu_hold = !done;
   // rom_addr is the write pointer itself: it presents the target address during
   // the strobe cycle and advances on the edge that ends it.
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         rom_we       <= 1'b0;
         rom_addr     <= '0;
         rom_data     <= '0;
         words_loaded <= '0;
      end else begin
         rom_we <= wr;
         if (wr) rom_data <= wr_word;
         if (rom_we) begin
            rom_addr     <= rom_addr + 1'b1;
            words_loaded <= words_loaded + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_hack_rom_loader.sv
// tb_hack_rom_loader: self-checking bench for hack_rom_loader
module tb_hack_rom_loader;
   import hack_pkg::*;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        rom_we;
   logic [14:0] rom_addr;
   logic [15:0] rom_data;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;
   int vectors = 0;
   int miscompares = 0;
   logic [31:0] wq[$];
   logic [31:0] m_w[$];
   bit          m_d;
   bit          m_e;

   typedef struct {
      int          len;
      logic [63:0] b;
      int          gap;
      bit          xd;
      bit          xe;
      int          nw;
      logic [15:0] w0;
      logic [15:0] w1;
   } vec_t;
   vec_t tbl[7];

   always #5 clk = ~clk;

   hack_rom_loader dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .rom_we       (rom_we),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always @(negedge clk) if (rom_we) wq.push_back({17'(rom_addr), rom_data});

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
      int n;
      n = 0;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      start    = poke;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) chk("accept_timeout", 32'(n), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic restart();
      if (done || error) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("restart in_ready", 32'(in_ready), 32'd1);
         chk("restart words_loaded", 32'(words_loaded), 32'd0);
         chk("restart rom_addr", 32'(rom_addr), 32'd0);
         chk("restart done/error", {30'd0, done, error}, 32'd0);
      end
   endtask

   // Reference: parse the frame straight from the byte list.
   task automatic model(input logic [7:0] q[$]);
      int n;
      logic [7:0] x;
      m_w.delete();
      n = int'({q[0], q[1]});
      x = q[0] ^ q[1];
      m_d = 1'b0;
      m_e = 1'b1;
      if (n <= 32768) begin
         for (int i = 0; i < n; i++) begin
            m_w.push_back({17'(i), q[2 + 2 * i], q[3 + 2 * i]});
            x = x ^ q[2 + 2 * i] ^ q[3 + 2 * i];
         end
         m_d = q[2 + 2 * n] == x;
         m_e = !m_d;
      end
   endtask

   task automatic run_frame(input logic [7:0] q[$], input int gap, input bit pokes,
                            input logic [31:0] ew[$], input bit xd, input bit xe, input string tag);
      wq.delete();
      foreach (q[i]) send_byte(q[i], int'($urandom_range(gap, 0)), pokes && ($urandom_range(1, 0) == 1));
      repeat (3) @(negedge clk);
      chk({tag, " write count"}, 32'(wq.size()), 32'(ew.size()));
      foreach (ew[i]) if (i < wq.size()) chk($sformatf("%s write %0d", tag, i), wq[i], ew[i]);
      chk({tag, " done"}, 32'(done), 32'(xd));
      chk({tag, " error"}, 32'(error), 32'(xe));
      chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'(!xd));
      chk({tag, " words_loaded"}, 32'(words_loaded), 32'(ew.size()));
      chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0]  q[$];
      logic [31:0] ew[$];
      logic [7:0]  x;
      int          n;
      tbl[0] = '{len: 7, b: 64'h0002_0002_E308_EB00, gap: 0, xd: 1, xe: 0, nw: 2, w0: 16'h0002, w1: 16'hE308};
      tbl[1] = '{len: 7, b: 64'h0002_0002_E308_EB00, gap: 5, xd: 1, xe: 0, nw: 2, w0: 16'h0002, w1: 16'hE308};
      tbl[2] = '{len: 5, b: 64'h0001_1234_0000_0000, gap: 2, xd: 0, xe: 1, nw: 1, w0: 16'h1234, w1: 16'h0000};
      tbl[3] = '{len: 2, b: 64'h8001_0000_0000_0000, gap: 1, xd: 0, xe: 1, nw: 0, w0: 16'h0000, w1: 16'h0000};
      tbl[4] = '{len: 3, b: 64'h0000_0000_0000_0000, gap: 0, xd: 1, xe: 0, nw: 0, w0: 16'h0000, w1: 16'h0000};
      tbl[5] = '{len: 5, b: 64'h0001_ABCD_6700_0000, gap: 3, xd: 1, xe: 0, nw: 1, w0: 16'hABCD, w1: 16'h0000};
      tbl[6] = '{len: 3, b: 64'h0000_0500_0000_0000, gap: 1, xd: 0, xe: 1, nw: 0, w0: 16'h0000, w1: 16'h0000};

      @(negedge clk);
      @(negedge clk);
      chk("reset in_ready", 32'(in_ready), 32'd0);
      chk("reset rom_we", 32'(rom_we), 32'd0);
      chk("reset rom_addr", 32'(rom_addr), 32'd0);
      chk("reset rom_data", 32'(rom_data), 32'd0);
      chk("reset cpu_hold", 32'(cpu_hold), 32'd1);
      chk("reset done/error", {30'd0, done, error}, 32'd0);
      chk("reset words_loaded", 32'(words_loaded), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle in_ready", 32'(in_ready), 32'd1);

      for (int v = 0; v < 7; v++) begin
         q.delete();
         ew.delete();
         for (int j = 0; j < tbl[v].len; j++) q.push_back(tbl[v].b[63 - 8 * j -: 8]);
         if (tbl[v].nw > 0) ew.push_back({17'd0, tbl[v].w0});
         if (tbl[v].nw > 1) ew.push_back({17'd1, tbl[v].w1});
         restart();
         run_frame(q, tbl[v].gap, 1'b0, ew, tbl[v].xd, tbl[v].xe, $sformatf("vec%0d", v));
      end

      restart();
      wq.delete();
      q = '{8'h00, 8'h02, 8'h00, 8'h02, 8'hE3};
      foreach (q[i]) send_byte(q[i], 0, 1'b0);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk("midreset in_ready", 32'(in_ready), 32'd0);
      chk("midreset rom_we", 32'(rom_we), 32'd0);
      chk("midreset rom_addr", 32'(rom_addr), 32'd0);
      chk("midreset rom_data", 32'(rom_data), 32'd0);
      chk("midreset cpu_hold", 32'(cpu_hold), 32'd1);
      chk("midreset done/error", {30'd0, done, error}, 32'd0);
      chk("midreset words_loaded", 32'(words_loaded), 32'd0);
      chk("midreset partial writes", 32'(wq.size()), 32'd1);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      q = '{8'h00, 8'h02, 8'h00, 8'h02, 8'hE3, 8'h08, 8'hEB};
      ew = '{{17'd0, 16'h0002}, {17'd1, 16'hE308}};
      run_frame(q, 0, 1'b0, ew, 1'b1, 1'b0, "after_reset");

      restart();
      send_byte(8'h80, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      @(negedge clk);
      chk("depth header error", 32'(error), 32'd0);
      chk("depth header in_ready", 32'(in_ready), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int f = 0; f < 25; f++) begin
         n = int'($urandom_range(20, 0));
         q.delete();
         q.push_back(8'(n >> 8));
         q.push_back(8'(n));
         x = 8'(n >> 8) ^ 8'(n);
         for (int j = 0; j < 2 * n; j++) begin
            q.push_back(8'($urandom));
            x = x ^ q[q.size() - 1];
         end
         q.push_back(($urandom_range(1, 0) == 1) ? x : x ^ 8'($urandom_range(255, 1)));
         model(q);
         restart();
         run_frame(q, 3, 1'b1, m_w, m_d, m_e, $sformatf("rand%0d", f));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
